// File: rtl/cxscreen_driver.sv
// cxscreen_driver
// Wishbone slave that scans a 7-pin charlieplexed LED screen.
// The screen has 42 LEDs arranged as 7 rows by 6 columns.
// The CPU fills a shadow frame buffer and requests a swap. The scanner copies
// the shadow into the active buffer only when it wraps from row 6 to row 0,
// so a frame is never shown half-updated. Each row is preceded by a blanking
// interval with every pin released, which keeps neighbouring rows from ghosting.
//
// Parameters
//   TICKS_PER_ROW : cycles each row is driven (>= 1)
//   BLANK_TICKS   : cycles every pin is released before each row (>= 1)
//
// Ports
//   clock        : system clock
//   reset        : synchronous active-high reset
//   wb_cyc_i     : Wishbone cycle
//   wb_stb_i     : Wishbone strobe
//   wb_we_i      : Wishbone write enable
//   wb_adr_i     : register select (0-6 shadow rows, 7 control)
//   wb_dat_i     : write data
//   wb_dat_o     : read data, valid while wb_ack_o is high
//   wb_ack_o     : one-cycle transfer acknowledge
//   cxscreen_oe  : per-pin output enable (0 = hi-Z)
//   cxscreen_o   : per-pin output level where enabled

module cxscreen_driver #(
   parameter int TICKS_PER_ROW = 4800,
   parameter int BLANK_TICKS   = 48
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       wb_cyc_i,
   input  logic       wb_stb_i,
   input  logic       wb_we_i,
   input  logic [2:0] wb_adr_i,
   input  logic [7:0] wb_dat_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   output logic [6:0] cxscreen_oe,
   output logic [6:0] cxscreen_o
);

   localparam int TICK_MAX = (TICKS_PER_ROW > BLANK_TICKS) ? TICKS_PER_ROW : BLANK_TICKS;
   localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam logic [TW-1:0] DRIVE_LAST = TW'(TICKS_PER_ROW - 1);
   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scanState_e;

   scanState_e      state_q, state_d;
   logic [2:0]      row_q, row_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic            wrapEdge;

   logic [6:0][5:0] active_q, active_d;
   logic [6:0][5:0] shadow_q, shadow_d;
   logic            pending_q, pending_d;
   logic            ack_q, ack_d;
   logic [7:0]      datO_q, datO_d;
   logic            accept;

   logic [6:0]      oe_q, oe_d;
   logic [6:0]      lvl_q, lvl_d;
   logic [6:0]      rowBit;
   logic [6:0]      belowRow;
   logic [6:0]      aboveRow;
   logic [5:0]      rowMask;

   // Scanner: BLANK then DRIVE on each row. The tick counter restarts at every
   // state change. wrapEdge marks the single edge where row 6 DRIVE ends, which
   // is the only place a buffer swap is allowed to land.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      tick_d   = tick_q + TW'(1);
      wrapEdge = 1'b0;
      case (state_q)
         BLANK: begin
            if (tick_q == BLANK_LAST) begin
               state_d = DRIVE;
               tick_d  = '0;
            end
         end
         DRIVE: begin
            if (tick_q == DRIVE_LAST) begin
               state_d  = BLANK;
               tick_d   = '0;
               row_d    = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
               wrapEdge = (row_q == 3'd6);
            end
         end
      endcase
   end

   // Register file and buffer swap. The swap samples the pending flag and the
   // shadow contents as they were before this edge. A CPU write on the same
   // edge therefore lands after the swap: a control write becomes the new
   // pending flag, and a shadow write stays in the shadow buffer only.
   always_comb begin
      accept    = wb_cyc_i & wb_stb_i & ~ack_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      ack_d     = accept;
      datO_d    = datO_q;

      if (wrapEdge && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      if (accept && wb_we_i) begin
         if (wb_adr_i == 3'd7) begin
            pending_d = wb_dat_i[0];
         end else begin
            shadow_d[wb_adr_i] = wb_dat_i[5:0];
         end
      end

      if (accept && !wb_we_i) begin
         if (wb_adr_i == 3'd7) begin
            datO_d = {7'b0, pending_q};
         end else begin
            datO_d = {2'b0, shadow_q[wb_adr_i]};
         end
      end
   end

   // Pin pattern for the coming cycle, built from next-state values so the pins
   // switch on the same edge as the scanner. The row pin drives high. Column c
   // uses pin c below the row pin and pin c+1 above it, so the mask is used
   // unshifted under the row bit and shifted up by one over it. A lit LED
   // enables its pin at level 0. An unlit LED leaves its pin released.
   always_comb begin
      oe_d     = 7'b0;
      lvl_d    = 7'b0;
      rowBit   = 7'b1 << row_d;
      belowRow = rowBit - 7'd1;
      aboveRow = ~(belowRow | rowBit);
      rowMask  = active_d[row_d];
      if (state_d == DRIVE) begin
         oe_d  = rowBit | ({1'b0, rowMask} & belowRow) | ({rowMask, 1'b0} & aboveRow);
         lvl_d = rowBit;
      end
   end

   // State registers. Reset releases every pin and clears both buffers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= BLANK;
         row_q     <= 3'd0;
         tick_q    <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         datO_q    <= 8'h00;
         oe_q      <= 7'b0;
         lvl_q     <= 7'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         tick_q    <= tick_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         datO_q    <= datO_d;
         oe_q      <= oe_d;
         lvl_q     <= lvl_d;
      end
   end

   assign wb_ack_o    = ack_q;
   assign wb_dat_o    = datO_q;
   assign cxscreen_oe = oe_q;
   assign cxscreen_o  = lvl_q;

endmodule

// File: tb/tb_cxscreen_driver.sv
// tb_cxscreen_driver
// Directed bench for cxscreen_driver, run with short timing: 2 blank ticks and
// 5 drive ticks, so a row lasts 7 cycles and a frame lasts 49 cycles.
// cycleNo counts the edges since the last reset edge. Its value modulo 49 is
// the scan position. Positions 0-1 of each 7-cycle row window are blank, and
// positions 2-6 drive the row.

module tb_cxscreen_driver;

   localparam int BLANK = 2;
   localparam int TPR   = 5;
   localparam int FRAME = 7 * (BLANK + TPR);

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       wbCyc = 1'b0;
   logic       wbStb = 1'b0;
   logic       wbWe  = 1'b0;
   logic [2:0] wbAdr = 3'd0;
   logic [7:0] wbDatI = 8'h00;
   logic [7:0] wbDatO;
   logic       wbAck;
   logic [6:0] pinOe;
   logic [6:0] pinLvl;

   int checks = 0;
   int errors = 0;
   int cycleNo = 0;

   cxscreen_driver #(
      .TICKS_PER_ROW(TPR),
      .BLANK_TICKS(BLANK)
   ) dut (
      .clock(clock),
      .reset(reset),
      .wb_cyc_i(wbCyc),
      .wb_stb_i(wbStb),
      .wb_we_i(wbWe),
      .wb_adr_i(wbAdr),
      .wb_dat_i(wbDatI),
      .wb_dat_o(wbDatO),
      .wb_ack_o(wbAck),
      .cxscreen_oe(pinOe),
      .cxscreen_o(pinLvl)
   );

   always #5 clock = ~clock;

   // Scan position reference: restarts at the last edge that sees reset high
   always @(posedge clock) begin
      if (reset) cycleNo <= 0;
      else       cycleNo <= cycleNo + 1;
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic doReset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
   endtask

   // Advance at least one cycle, stopping at the negedge of scan position target
   task automatic waitPos(input int target);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while ((cycleNo % FRAME) != target && n < 200);
      if ((cycleNo % FRAME) != target) begin
         checks++;
         errors++;
         $display("[TB] FAIL waitPos: position %0d, required %0d", cycleNo % FRAME, target);
      end
   endtask

   task automatic wbWrite(input logic [2:0] adr, input logic [7:0] dat);
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbAdr = adr; wbDatI = dat;
      @(negedge clock);
      wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
      @(negedge clock);
   endtask

   task automatic wbRead(input logic [2:0] adr, output logic [7:0] dat, output logic ack);
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b0; wbAdr = adr;
      @(negedge clock);
      dat = wbDatO;
      ack = wbAck;
      wbCyc = 1'b0; wbStb = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      logic       a;
      doReset();
      wbWrite(3'd3, 8'h2A);
      wbWrite(3'd7, 8'h01);
      waitPos(48);
      waitPos(23);
      checks++;
      if (pinOe !== 7'h5A) begin errors++; $display("[TB] FAIL reset_pre_oe: got %h, expected %h", pinOe, 7'h5A); end
      checks++;
      if (pinLvl !== 7'h08) begin errors++; $display("[TB] FAIL reset_pre_o: got %h, expected %h", pinLvl, 7'h08); end
      wbRead(3'd3, d, a);
      checks++;
      if (d !== 8'h2A || a !== 1'b1) begin errors++; $display("[TB] FAIL reset_pre_read: got %h ack %b, expected 2a ack 1", d, a); end
      doReset();
      checks++;
      if (pinOe !== 7'h00 || pinLvl !== 7'h00) begin errors++; $display("[TB] FAIL reset_pins: oe %h o %h, expected 00 00", pinOe, pinLvl); end
      checks++;
      if (wbAck !== 1'b0 || wbDatO !== 8'h00) begin errors++; $display("[TB] FAIL reset_bus: ack %b dat %h, expected 0 00", wbAck, wbDatO); end
      for (int i = 0; i < 8; i++) begin
         wbRead(3'(i), d, a);
         checks++;
         if (d !== 8'h00 || a !== 1'b1) begin errors++; $display("[TB] FAIL reset_read%0d: got %h ack %b, expected 00 ack 1", i, d, a); end
      end
      waitPos(23);
      checks++;
      if (pinOe !== 7'h08) begin errors++; $display("[TB] FAIL reset_active_cleared: got %h, expected %h", pinOe, 7'h08); end
   endtask

   task automatic test_cadence();
      int p;
      logic [6:0] exp;
      waitPos(0);
      for (int i = 0; i < 2 * FRAME; i++) begin
         p = i % FRAME;
         exp = ((p % 7) >= 2) ? 7'(1 << (p / 7)) : 7'h00;
         checks++;
         if (pinOe !== exp || pinLvl !== exp) begin
            errors++;
            $display("[TB] FAIL cadence_cycle%0d: oe %h o %h, expected %h %h", i, pinOe, pinLvl, exp, exp);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_mapping();
      logic [6:0] mapOe [7] = '{7'h01, 7'h02, 7'h0D, 7'h08, 7'h10, 7'h20, 7'h40};
      logic [6:0] expOe;
      logic [6:0] expLvl;
      logic [7:0] d;
      logic       a;
      doReset();
      waitPos(30);
      wbWrite(3'd2, 8'h05);
      wbWrite(3'd7, 8'h01);
      waitPos(0);
      for (int i = 0; i < FRAME; i++) begin
         expOe  = ((i % 7) >= 2) ? mapOe[i / 7] : 7'h00;
         expLvl = ((i % 7) >= 2) ? 7'(1 << (i / 7)) : 7'h00;
         checks++;
         if (pinOe !== expOe || pinLvl !== expLvl) begin
            errors++;
            $display("[TB] FAIL mapping_pos%0d: oe %h o %h, expected %h %h", i, pinOe, pinLvl, expOe, expLvl);
         end
         @(negedge clock);
      end
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL mapping_ctrl: got %h, expected 00", d); end
   endtask

   task automatic test_tear_free();
      logic [7:0] d;
      logic       a;
      waitPos(10);
      wbWrite(3'd0, 8'h3F);
      wbWrite(3'd7, 8'h01);
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h01) begin errors++; $display("[TB] FAIL tear_pending: got %h, expected 01", d); end
      waitPos(18);
      checks++;
      if (pinOe !== 7'h0D) begin errors++; $display("[TB] FAIL tear_row2_old: got %h, expected 0d", pinOe); end
      waitPos(44);
      checks++;
      if (pinOe !== 7'h40) begin errors++; $display("[TB] FAIL tear_row6_old: got %h, expected 40", pinOe); end
      waitPos(2);
      checks++;
      if (pinOe !== 7'h7F || pinLvl !== 7'h01) begin errors++; $display("[TB] FAIL tear_row0_new: oe %h o %h, expected 7f 01", pinOe, pinLvl); end
      waitPos(16);
      checks++;
      if (pinOe !== 7'h0D) begin errors++; $display("[TB] FAIL tear_row2_kept: got %h, expected 0d", pinOe); end
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL tear_ctrl_clear: got %h, expected 00", d); end
   endtask

   task automatic test_wishbone();
      logic expAck [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [7:0] d;
      logic       a;
      doReset();
      wbCyc = 1'b1; wbStb = 1'b1; wbWe = 1'b1; wbAdr = 3'd5; wbDatI = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checks++;
         if (wbAck !== expAck[i]) begin errors++; $display("[TB] FAIL held_stb_ack%0d: got %b, expected %b", i, wbAck, expAck[i]); end
      end
      wbCyc = 1'b0; wbStb = 1'b0; wbWe = 1'b0;
      @(negedge clock);
      wbRead(3'd5, d, a);
      checks++;
      if (d !== 8'h3F || a !== 1'b1) begin errors++; $display("[TB] FAIL mask_read: got %h ack %b, expected 3f ack 1", d, a); end
      waitPos(10);
      wbWrite(3'd1, 8'h01);
      wbWrite(3'd7, 8'h01);
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h01) begin errors++; $display("[TB] FAIL cancel_set: got %h, expected 01", d); end
      wbWrite(3'd7, 8'h00);
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL cancel_clear: got %h, expected 00", d); end
      waitPos(0);
      waitPos(9);
      checks++;
      if (pinOe !== 7'h02) begin errors++; $display("[TB] FAIL cancel_row1: got %h, expected 02", pinOe); end
      waitPos(37);
      checks++;
      if (pinOe !== 7'h20) begin errors++; $display("[TB] FAIL cancel_row5: got %h, expected 20", pinOe); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] d;
      logic       a;
      doReset();
      waitPos(10);
      wbWrite(3'd4, 8'h01);
      wbWrite(3'd7, 8'h01);
      waitPos(48);
      wbWrite(3'd7, 8'h00);
      waitPos(30);
      checks++;
      if (pinOe !== 7'h11 || pinLvl !== 7'h10) begin errors++; $display("[TB] FAIL simul_ctrl_swap: oe %h o %h, expected 11 10", pinOe, pinLvl); end
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL simul_ctrl_pending: got %h, expected 00", d); end
      waitPos(10);
      wbWrite(3'd4, 8'h02);
      wbWrite(3'd7, 8'h01);
      waitPos(48);
      wbWrite(3'd4, 8'h04);
      waitPos(30);
      checks++;
      if (pinOe !== 7'h12) begin errors++; $display("[TB] FAIL simul_shadow_old: got %h, expected 12", pinOe); end
      wbRead(3'd4, d, a);
      checks++;
      if (d !== 8'h04) begin errors++; $display("[TB] FAIL simul_shadow_read: got %h, expected 04", d); end
      wbRead(3'd7, d, a);
      checks++;
      if (d !== 8'h00) begin errors++; $display("[TB] FAIL simul_shadow_pending: got %h, expected 00", d); end
      wbWrite(3'd7, 8'h01);
      waitPos(30);
      checks++;
      if (pinOe !== 7'h14) begin errors++; $display("[TB] FAIL simul_shadow_next: got %h, expected 14", pinOe); end
   endtask

   // Test sequence
   initial begin
      @(negedge clock);
      test_reset();
      test_cadence();
      test_mapping();
      test_tear_free();
      test_wishbone();
      test_simultaneous();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cxscreen_driver.md
# cxscreen_driver

Wishbone-slave scan driver for the 7-pin charlieplexed LED screen (42 LEDs: 7 rows × 6 columns). The CPU writes column masks into a double-buffered frame store. The block time-multiplexes one row at a time onto the `cxscreen_oe`/`cxscreen_o` pin pairs, which the board level hands to the tristate I/O cells. A blanking interval separates every row to suppress ghosting. Frame swaps happen only at frame boundaries, so updates are tear-free.

## Interface
- `TICKS_PER_ROW`, 4800: clock cycles each row is driven (100 µs at 48 MHz); must be ≥ 1.
- `BLANK_TICKS`, 48: clock cycles all pins are released before each row; must be ≥ 1.

- `clock` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `wb_cyc_i` in 1: Wishbone cycle.
- `wb_stb_i` in 1: Wishbone strobe.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 3: register select.
- `wb_dat_i` in 8: write data.
- `wb_dat_o` out 8: read data.
- `wb_ack_o` out 1: transfer acknowledge.
- `cxscreen_oe` out 7: per-pin output enable; 0 means hi-Z.
- `cxscreen_o` out 7: per-pin output level, meaningful only where `oe` = 1.

## Operation
- **Registers**
  - Addresses 0–6: shadow row r. Bits [5:0] are the column mask; bits [7:6] are ignored on write and read as 0.
  - Address 7: control. Bit 0 is `swap_pending`; other bits read as 0.
    - Writing bit0 = 1 requests a swap; writing 0 cancels any pending swap.
- **Buffers.** The active buffer (7×6) drives the pins; the shadow buffer (7×6) is the CPU-visible copy. Reads of addresses 0–6 return shadow contents, not active.
- **Swap.** Occurs on the edge where the scanner wraps from row 6 DRIVE to row 0 BLANK. If the old `swap_pending` = 1, then active ← shadow and `swap_pending` clears.
- **Pin mapping for row r**
  - Pin r is the row pin: `oe[r]` = 1, `o[r]` = 1.
  - Column bit c (0–5) maps to pin p = c when c < r, otherwise c+1.
  - LED on: `oe[p]` = 1, `o[p]` = 0. LED off: `oe[p]` = 0, `o[p]` = 0.
- **Scanner FSM**
  - States are BLANK and DRIVE, with row counter 0–6 and a tick counter.
  - BLANK: all `oe` = 0, `o` = 0. Lasts `BLANK_TICKS` cycles, then → DRIVE on the same row.
  - DRIVE: pins follow the mapping above using the active buffer. Lasts `TICKS_PER_ROW` cycles, then → BLANK with row = (row+1) mod 7.
- **Simultaneous events**
  - Control write in the same cycle as the swap edge: the swap uses the old `swap_pending`. The written bit then becomes the new `swap_pending`.
  - Shadow write in the same cycle as a swap: the active buffer copies the pre-write shadow.

## Timing
- **Reset values.** All of the following are 0 after reset:
  - `cxscreen_oe`, `cxscreen_o`, `wb_ack_o`, `wb_dat_o`.
  - Both buffers and `swap_pending`.
  - Scanner: state = BLANK, row = 0, tick counter = 0.
- **Scan cadence.**
  - Row 0 BLANK starts in the first cycle after reset deasserts.
  - Row period is `BLANK_TICKS` + `TICKS_PER_ROW` cycles; frame period is 7× the row period.
- **Pin outputs.** Registered. They change on the same edge as the FSM state/row change, so there is no extra lag. They never change mid-state unless a swap lands exactly there, which can only happen at the row 6→0 edge.
- **Wishbone**
  - The slave accepts a request when `cyc` & `stb` & !`ack`.
  - `wb_ack_o` pulses high for exactly one cycle on the edge after acceptance, giving one wait-free cycle of latency.
  - A held `stb` yields ack every other cycle.
  - The write takes effect on the accepting edge.
  - `wb_dat_o` is valid in the ack cycle and holds its value otherwise.
- **Reset mid-operation.** Reset in any state forces all pins to hi-Z on the next edge and clears both buffers.

## Test plan
- **Reset:** assert `reset` for 3 cycles during row 3 DRIVE → the next cycle shows `oe` = 0, `o` = 0, `ack` = 0; readback of addresses 0–7 all returns 0x00.
- **Cadence:** `BLANK_TICKS` = 2, `TICKS_PER_ROW` = 5 → a non-zero `oe` appears on cycles 2–6 of every 7-cycle row window; the frame repeats every 49 cycles.
- **Mapping:**
  - Write row 2 = 0x05, then control = 0x01.
  - After the next frame boundary, row 2 DRIVE shows `oe` = 7'b0001101, `o` = 7'b0000100.
  - Rows 0, 1 and 3–6 DRIVE show only their own row-pin bit set.
- **Tear-free swap:**
  - Write row 0 = 0x3F and control = 1 mid-frame → the active buffer is unchanged until the row 6→0 edge.
  - Row 0 then shows `oe` = 7'h7F, `o` = 7'h01.
  - Control then reads back 0x00.
- **Wishbone:**
  - Hold `stb` for 4 cycles on a write → `ack` is high on cycles 2 and 4 only.
  - Write 0xFF to address 5 → reads back 0x3F.
  - A write of 0 to control cancels a pending swap, so the active buffer stays unchanged past the boundary.
- **Simultaneous events:**
  - A control write of 0 on the exact swap edge while pending = 1 → the swap still occurs and pending ends at 0.
  - A shadow write on the same edge → the active buffer holds the old value.
